// File: rtl/legv8_pkg.sv
// Shared LEGv8 encodings: branch kinds, B.cond condition codes and PC sequencer states.
package legv8_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_BL   = 3'd2,
    BR_CBZ  = 3'd3,
    BR_CBNZ = 3'd4,
    BR_COND = 3'd5,
    BR_REG  = 3'd6,
    BR_RSVD = 3'd7
  } br_kind_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// B.cond evaluator: combinational pass bit from {N,Z,C,V} and a 4-bit condition code.
module cond_eval
  import legv8_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       pass_o
);

  logic n, z, c, v, gt;

  assign n  = flags_i[3];
  assign z  = flags_i[2];
  assign c  = flags_i[1];
  assign v  = flags_i[0];
  assign gt = !z && (n == v);

  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_HS: pass_o = c;
      COND_LO: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !(c && !z);
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = gt;
      COND_LE: pass_o = !gt;
      default: pass_o = 1'b1;  // AL and NV both always pass
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// LEGv8 program counter with branch resolution, stall hold and RUN/HALTED sequencing.
// Define PC_PERF_EN to add retired/taken 32-bit performance counters.
module pc_branch_unit
  import legv8_pkg::*;
#(
  parameter int              ADDR_W    = 64,
  parameter int              BYTE_ADDR = 0,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        br_kind,
  input  logic [31:0]       instr,
  input  logic              zero,
  input  logic [3:0]        flags,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              taken,
  output logic              halted
`ifdef PC_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       taken_cnt
`endif
);

  // state     | meaning
  // ST_RUN    | fetching; pc advances to next PC each unstalled edge
  // ST_HALTED | pc frozen until resume, which skips the halt instruction

  localparam int              SH   = (BYTE_ADDR != 0) ? 2 : 0;
  localparam logic [ADDR_W-1:0] STEP = (BYTE_ADDR != 0) ? ADDR_W'(4) : ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] off26, off19, offset, next_pc, seq_pc;
  logic              cond_pass, cond_ok, use_reg, running;

  cond_eval u_cond (
    .flags_i (flags),
    .cond_i  (instr[3:0]),
    .pass_o  (cond_pass)
  );

  assign off26  = ADDR_W'($signed(instr[25:0])) << SH;
  assign off19  = ADDR_W'($signed(instr[23:5])) << SH;
  assign seq_pc = pc_q + STEP;

  always_comb begin
    cond_ok = 1'b0;
    use_reg = 1'b0;
    offset  = off26;
    case (br_kind)
      BR_B, BR_BL: cond_ok = 1'b1;
      BR_CBZ:  begin cond_ok = zero;      offset = off19; end
      BR_CBNZ: begin cond_ok = !zero;     offset = off19; end
      BR_COND: begin cond_ok = cond_pass; offset = off19; end
      BR_REG:  begin cond_ok = 1'b1;      use_reg = 1'b1; end
      default: cond_ok = 1'b0;
    endcase
  end

  assign running = (state_q == ST_RUN) && !stall && !halt_req;
  assign taken   = cond_ok && running;
  assign next_pc = !taken ? seq_pc : (use_reg ? reg_target : pc_q + offset);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (halt_req) state_d = ST_HALTED;
          else          pc_d    = next_pc;
        end
        ST_HALTED: begin
          if (resume) begin
            state_d = ST_RUN;
            pc_d    = seq_pc;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign link_addr = seq_pc;
  assign halted    = (state_q == ST_HALTED);

`ifdef PC_PERF_EN
  logic [31:0] retired_q, taken_cnt_q;

  // taken already implies an unstalled RUN update without halt_req
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q   <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (running) retired_q   <= retired_q + 32'd1;
      if (taken)   taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_cnt_q;
`endif

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:26], instr[4]};

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed scoreboard bench for pc_branch_unit: word, byte and 8-bit address variants.
module tb_pc_branch_unit;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, zero, halt_req, resume;
  logic [2:0]  br_kind;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic [63:0] reg_target;
  logic [63:0] pc, link_addr;
  logic        taken, halted;

  logic [2:0]  k1, k2;
  logic [31:0] ins1, ins2;
  logic [63:0] pc1, link1;
  logic [7:0]  pc2, link2;
  logic        taken1, halted1, taken2, halted2;

`ifdef PC_PERF_EN
  logic [31:0] ret0, tkc0, ret1, tkc1, ret2, tkc2;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  int exp_ret = 0;
  int exp_tkn = 0;
  logic [63:0] cur_pc;
  logic        mdl_halted;
  logic [63:0] sb_pc[$];
  logic        sb_h[$];
  logic [63:0] sb_pc1[$];
  logic [63:0] sb_pc2[$];

  always #5 clk = ~clk;

  pc_branch_unit #(.ADDR_W(64), .BYTE_ADDR(0), .RESET_PC(64'd0)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .br_kind(br_kind), .instr(instr),
    .zero(zero), .flags(flags), .reg_target(reg_target), .halt_req(halt_req),
    .resume(resume), .pc(pc), .link_addr(link_addr), .taken(taken), .halted(halted)
`ifdef PC_PERF_EN
    , .retired_cnt(ret0), .taken_cnt(tkc0)
`endif
  );

  pc_branch_unit #(.ADDR_W(64), .BYTE_ADDR(1), .RESET_PC(64'd0)) u1 (
    .clk(clk), .rst(rst), .stall(1'b0), .br_kind(k1), .instr(ins1),
    .zero(1'b0), .flags(4'h0), .reg_target(64'd0), .halt_req(1'b0),
    .resume(1'b0), .pc(pc1), .link_addr(link1), .taken(taken1), .halted(halted1)
`ifdef PC_PERF_EN
    , .retired_cnt(ret1), .taken_cnt(tkc1)
`endif
  );

  pc_branch_unit #(.ADDR_W(8), .BYTE_ADDR(0), .RESET_PC(8'd0)) u2 (
    .clk(clk), .rst(rst), .stall(1'b0), .br_kind(k2), .instr(ins2),
    .zero(1'b0), .flags(4'h0), .reg_target(8'd0), .halt_req(1'b0),
    .resume(1'b0), .pc(pc2), .link_addr(link2), .taken(taken2), .halted(halted2)
`ifdef PC_PERF_EN
    , .retired_cnt(ret2), .taken_cnt(tkc2)
`endif
  );

  function automatic logic [31:0] enc26(input int imm);
    logic [31:0] t;
    t = imm;
    return {6'b0, t[25:0]};
  endfunction

  function automatic logic [31:0] enc19(input int imm, input logic [3:0] cond);
    logic [31:0] t;
    t = imm;
    return {8'b0, t[18:0], 1'b0, cond};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] k, input logic [31:0] ins, input logic z,
                     input logic [3:0] f, input logic [63:0] rt, input logic st,
                     input logic hr, input logic rs, input logic exp_tk,
                     input logic [63:0] exp_pc, input logic exp_h);
    logic [63:0] p;
    logic        h;
    br_kind = k; instr = ins; zero = z; flags = f; reg_target = rt;
    stall = st; halt_req = hr; resume = rs;
    #2;
    chk("taken", {63'd0, taken}, {63'd0, exp_tk});
    chk("link_addr", link_addr, cur_pc + 64'd1);
    if (!st && !mdl_halted && !hr) begin
      exp_ret++;
      if (exp_tk) exp_tkn++;
    end
    sb_pc.push_back(exp_pc);
    sb_h.push_back(exp_h);
    @(posedge clk);
    #1;
    p = sb_pc.pop_front();
    h = sb_h.pop_front();
    chk("pc", pc, p);
    chk("halted", {63'd0, halted}, {63'd0, h});
    cur_pc     = p;
    mdl_halted = h;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; zero = 1'b0; halt_req = 1'b0; resume = 1'b0;
    br_kind = 3'd0; instr = 32'd0; flags = 4'd0; reg_target = 64'd0;
    k1 = 3'd0; k2 = 3'd0; ins1 = 32'd0; ins2 = 32'd0;
    cur_pc = 64'd0; mdl_halted = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 64'd0);
    chk("reset_halted", {63'd0, halted}, 64'd0);
    chk("reset_taken", {63'd0, taken}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // idle sequential fetch
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 0, 0, 0, 64'd1, 0);
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 0, 0, 0, 64'd2, 0);
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 0, 0, 0, 64'd3, 0);
    // unconditional and link
    cyc(BR_B,  enc26(7),  0, 4'h0, 64'd0, 0, 0, 0, 1, 64'd10, 0);
    cyc(BR_B,  enc26(-4), 0, 4'h0, 64'd0, 0, 0, 0, 1, 64'd6,  0);
    cyc(BR_B,  enc26(4),  0, 4'h0, 64'd0, 0, 0, 0, 1, 64'd10, 0);
    cyc(BR_BL, enc26(10), 0, 4'h0, 64'd0, 0, 0, 0, 1, 64'd20, 0);
    // compare-and-branch
    cyc(BR_CBZ,  enc19(5, 4'h0), 1, 4'h0, 64'd0, 0, 0, 0, 1, 64'd25, 0);
    cyc(BR_B,    enc26(-5),      0, 4'h0, 64'd0, 0, 0, 0, 1, 64'd20, 0);
    cyc(BR_CBZ,  enc19(5, 4'h0), 0, 4'h0, 64'd0, 0, 0, 0, 0, 64'd21, 0);
    cyc(BR_CBNZ, enc19(5, 4'h0), 0, 4'h0, 64'd0, 0, 0, 0, 1, 64'd26, 0);
    cyc(BR_CBNZ, enc19(5, 4'h0), 1, 4'h0, 64'd0, 0, 0, 0, 0, 64'd27, 0);
    // B.cond
    cyc(BR_COND, enc19(3, COND_GT), 0, 4'b1001, 64'd0, 0, 0, 0, 1, 64'd30, 0);
    cyc(BR_COND, enc19(3, COND_GT), 0, 4'b0100, 64'd0, 0, 0, 0, 0, 64'd31, 0);
    cyc(BR_COND, enc19(2, COND_EQ), 0, 4'b0100, 64'd0, 0, 0, 0, 1, 64'd33, 0);
    cyc(BR_COND, enc19(2, COND_HS), 0, 4'b0000, 64'd0, 0, 0, 0, 0, 64'd34, 0);
    cyc(BR_COND, enc19(2, COND_LT), 0, 4'b1000, 64'd0, 0, 0, 0, 1, 64'd36, 0);
    cyc(BR_COND, enc19(2, COND_NV), 0, 4'b0000, 64'd0, 0, 0, 0, 1, 64'd38, 0);
    cyc(BR_COND, enc19(2, COND_LE), 0, 4'b0000, 64'd0, 0, 0, 0, 0, 64'd39, 0);
    cyc(BR_COND, enc19(2, COND_HI), 0, 4'b0010, 64'd0, 0, 0, 0, 1, 64'd41, 0);
    // register-indirect, then stalled branch
    cyc(BR_REG, enc26(3), 0, 4'h0, 64'h1234, 0, 0, 0, 1, 64'h1234, 0);
    cyc(BR_REG, enc26(3), 0, 4'h0, 64'd7,    1, 0, 0, 0, 64'h1234, 0);
    cyc(BR_REG, enc26(3), 0, 4'h0, 64'd7,    1, 0, 0, 0, 64'h1234, 0);
    cyc(BR_REG, enc26(3), 0, 4'h0, 64'd7,    0, 0, 0, 1, 64'd7,    0);
    // halt with a branch in the same cycle, then hold
    cyc(BR_B, enc26(9), 0, 4'h0, 64'd0, 0, 1, 0, 0, 64'd7, 1);
    for (int i = 0; i < 5; i++)
      cyc(BR_B, enc26(9), 0, 4'h0, 64'd0, 0, (i == 2), 0, 0, 64'd7, 1);
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 1, 0, 1, 0, 64'd7, 1);
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 0, 1, 0, 64'd8, 0);

`ifdef PC_PERF_EN
    chk("retired_cnt", {32'd0, ret0}, 64'(exp_ret));
    chk("taken_cnt",   {32'd0, tkc0}, 64'(exp_tkn));
`endif

    // halt again, then asynchronous reset mid-cycle
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 1, 0, 0, 64'd8, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_pc", pc, 64'd0);
    chk("async_rst_halted", {63'd0, halted}, 64'd0);
`ifdef PC_PERF_EN
    chk("rst_retired_cnt", {32'd0, ret0}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    cur_pc = 64'd0;
    mdl_halted = 1'b0;

    // byte-addressed and 8-bit variants
    k1 = BR_B; ins1 = enc26(10);
    k2 = BR_B; ins2 = enc26(-1);
    sb_pc1.push_back(64'd40); sb_pc2.push_back(64'hFF);
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 0, 0, 0, 64'd1, 0);
    chk("byte_pc", pc1, sb_pc1.pop_front());
    chk("w8_pc", {56'd0, pc2}, sb_pc2.pop_front());

    k1 = BR_B; ins1 = enc26(-4);
    k2 = BR_NONE; ins2 = 32'd0;
    sb_pc1.push_back(64'd24); sb_pc2.push_back(64'h00);
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 0, 0, 0, 64'd2, 0);
    chk("byte_pc", pc1, sb_pc1.pop_front());
    chk("w8_wrap_pc", {56'd0, pc2}, sb_pc2.pop_front());

    k1 = BR_NONE; ins1 = 32'd0;
    sb_pc1.push_back(64'd28); sb_pc2.push_back(64'h01);
    cyc(BR_NONE, 32'd0, 0, 4'h0, 64'd0, 0, 0, 0, 0, 64'd3, 0);
    chk("byte_step_pc", pc1, sb_pc1.pop_front());
    chk("w8_pc", {56'd0, pc2}, sb_pc2.pop_front());
    chk("byte_link", link1, 64'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised program-counter successor for the LEGv8 datapath: holds the fetch PC and resolves the next PC every cycle.
- Resolves sequential fetch, B/BL, CBZ/CBNZ, B.cond (NZCV condition codes), and BR (register-indirect) branches.
- Adds stall hold, a RUN/HALTED state machine, and a BL link-address output.
- Sits between the control unit / ALU flag outputs and instruction memory; the PC updates on the rising edge only.

Parameters:
- ADDR_W, 64, PC and target width.
- BYTE_ADDR, 0, 0 = PC counts words (step 1, offset used as-is); 1 = PC counts bytes (step 4, offset shifted left 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- stall  in  1  hold PC and state this cycle.
- br_kind  in  3  0 = none, 1 = B, 2 = BL, 3 = CBZ, 4 = CBNZ, 5 = B.cond, 6 = BR, 7 = reserved (treated as none).
- instr  in  32  current instruction; immediates and condition code are taken from it.
- zero  in  1  ALU zero flag, used by CBZ/CBNZ.
- flags  in  4  {N,Z,C,V}, used by B.cond.
- reg_target  in  ADDR_W  register value for BR.
- halt_req  in  1  current instruction is a halt.
- resume  in  1  leave HALTED.
- pc  out  ADDR_W  current fetch address.
- link_addr  out  ADDR_W  pc + STEP, combinational; written to X30 on BL.
- taken  out  1  combinational; branch taken this cycle.
- halted  out  1  state == HALTED.

Behaviour:
- Reset (rst = 0, asynchronous): pc = RESET_PC, state = RUN, halted = 0. taken depends only on inputs.
- STEP = BYTE_ADDR ? 4 : 1. SH = BYTE_ADDR ? 2 : 0.
- Offsets (sign-extended to ADDR_W, then << SH):
  - B/BL: imm26 = instr[25:0].
  - CBZ/CBNZ/B.cond: imm19 = instr[23:5].
- Taken conditions:
  - B, BL, BR: always taken.
  - CBZ: zero. CBNZ: !zero.
  - B.cond on instr[3:0]: EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !GT, 1110/1111 always.
- taken = 0 whenever: state is HALTED, stall = 1, or halt_req = 1.
- Next PC:
  - BR taken: reg_target, unshifted, unmodified.
  - Other branch taken: pc + offset.
  - Otherwise: pc + STEP.
  - All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Per-edge priority: reset > stall (hold everything) > state action.
- RUN state:
  - halt_req = 1: pc holds, state moves to HALTED; any branch in the same cycle is ignored.
  - Otherwise: pc <= next PC.
- HALTED state:
  - pc holds.
  - resume = 1 (and stall = 0): state moves to RUN and pc <= pc + STEP in the same edge (skips the halt instruction).
  - halt_req is ignored while HALTED.
- Latency: new PC is visible one rising edge after the decision inputs are sampled. No negedge logic.
- Reset asserted mid-HALTED or mid-stall returns the block to RUN at RESET_PC immediately.

Optional Feature:
- Macro: PC_PERF_EN.
- When defined, adds two outputs, each 32 bits, reset to 0, wrapping at 2^32:
  - retired_cnt: +1 on each edge where pc updates in RUN.
  - taken_cnt: +1 on each edge where taken = 1 and pc updates.
  - Neither counter changes on stall, halt entry, resume, or while HALTED.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package legv8_pkg holds:
  - br_kind encodings (BR_NONE..BR_REG).
  - Condition-code constants (COND_EQ..COND_AL).
  - State encoding (ST_RUN, ST_HALTED).
- One sub-module, cond_eval: combinational, takes flags and cond[3:0], returns the B.cond pass bit. Reused by a future pipelined flag-forwarding stage.

Test Plan:
- Reset then 3 idle cycles (br_kind = 0, BYTE_ADDR = 0) -> pc = 0, 1, 2, 3; taken = 0.
- At pc = 10, B with imm26 = 0x3FFFFFC (-4) -> pc = 6. BYTE_ADDR = 1 variant: pc 40 -> 24. At pc = 10, BL -> link_addr = 11 in that cycle.
- CBZ imm19 = 5 at pc = 20 with zero = 1 -> pc = 25. Same with zero = 0 -> pc = 21. CBNZ inverts both.
- B.cond GT (1100) with {N,Z,C,V} = 1001 -> taken, pc += imm. With 0100 -> not taken. BR with reg_target = 0x1234 -> pc = 0x1234.
- stall = 1 for 2 cycles during a taken branch -> pc unchanged. Then halt_req at pc = 7 -> halted = 1, pc stays 7 for 5 cycles. resume -> pc = 8, halted = 0. Reset asserted while HALTED -> pc = 0 asynchronously.
- ADDR_W = 8, pc = 0xFF, no branch -> pc = 0x00. PC_PERF_EN defined: counters match the retired/taken counts above.
